// File: rtl/iitb_pkg.sv
// Shared IITB-RISC pipeline types and widths.
// EX/MEM bundle layout and ALU op-code flag bits.
package iitb_pkg;
  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int OP_W   = 6;

  localparam int ALU_OP_CARRY_BIT = 3;
  localparam int ALU_OP_ZERO_BIT  = 2;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [REG_AW-1:0] rd;
    logic              rf_we;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] store_data;
    logic [DATA_W-1:0] pc;
  } ex_mem_t;
endpackage

// File: rtl/ex_mem_latch_if.sv
// EX-side inputs and MEM-side outputs of the EX/MEM register.
// slave = the latch, master = the EX stage / consumer.
interface ex_mem_latch_if;
  import iitb_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] alu_out;
  logic              alu_carry;
  logic              alu_zero;
  logic              alu_block_write_en;
  logic [OP_W-1:0]   alu_op;
  logic [REG_AW-1:0] rd_in;
  logic              rf_we_in;
  logic              mem_we_in;
  logic              mem_re_in;
  logic [DATA_W-1:0] store_data_in;
  logic [DATA_W-1:0] pc_in;

  logic              out_valid;
  logic [DATA_W-1:0] result;
  logic [REG_AW-1:0] rd_out;
  logic              rf_we_out;
  logic              mem_we_out;
  logic              mem_re_out;
  logic [DATA_W-1:0] store_data_out;
  logic [DATA_W-1:0] pc_out;
  logic              carry_flag;
  logic              zero_flag;

  modport slave (
    input  in_valid, alu_out, alu_carry, alu_zero,
    input  alu_block_write_en, alu_op, rd_in,
    input  rf_we_in, mem_we_in, mem_re_in,
    input  store_data_in, pc_in,
    output out_valid, result, rd_out,
    output rf_we_out, mem_we_out, mem_re_out,
    output store_data_out, pc_out,
    output carry_flag, zero_flag
  );

  modport master (
    output in_valid, alu_out, alu_carry, alu_zero,
    output alu_block_write_en, alu_op, rd_in,
    output rf_we_in, mem_we_in, mem_re_in,
    output store_data_in, pc_in,
    input  out_valid, result, rd_out,
    input  rf_we_out, mem_we_out, mem_re_out,
    input  store_data_out, pc_out,
    input  carry_flag, zero_flag
  );
endinterface

// File: rtl/ex_mem_latch_flag_reg.sv
// Architectural carry/zero flags.
// EX writer is younger than the MEM load writer, so it wins.
module flag_reg (
  input  logic clk,
  input  logic rst_n,
  input  logic c_ex_we,
  input  logic c_ex,
  input  logic z_ex_we,
  input  logic z_ex,
  input  logic z_mem_we,
  input  logic z_mem,
  output logic carry,
  output logic zero
);

  // carry: only the EX stage writes it
  always_ff @(posedge clk) begin
    if (!rst_n)
      carry <= 1'b0;
    else if (c_ex_we)
      carry <= c_ex;
  end

  // zero: EX update first, then MEM load update
  always_ff @(posedge clk) begin
    if (!rst_n)
      zero <= 1'b0;
    else if (z_ex_we)
      zero <= z_ex;
    else if (z_mem_we)
      zero <= z_mem;
  end

endmodule

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register with stall/flush and
// conditional-execute qualification of write enables.
module ex_mem_latch
  import iitb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic stall,
  input  logic flush,
  input  logic mem_zero_we,
  input  logic mem_zero,
  ex_mem_latch_if.slave bus
);

  ex_mem_t d;
  ex_mem_t q;
  logic    vld;
  logic    ok;
  logic    commit;
  logic    exec;

  assign commit = bus.in_valid & ~stall & ~flush;
  assign exec   = commit & bus.alu_block_write_en;
  assign ok     = bus.in_valid & bus.alu_block_write_en;

  // next bundle with enables qualified by the condition result
  always_comb begin
    d            = '0;
    d.result     = bus.alu_out;
    d.rd         = bus.rd_in;
    d.rf_we      = bus.rf_we_in & ok;
    d.mem_we     = bus.mem_we_in & ok;
    d.mem_re     = bus.mem_re_in & ok;
    d.store_data = bus.store_data_in;
    d.pc         = bus.pc_in;
  end

  // pipeline register: flush bubbles, stall holds
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q   <= '0;
      vld <= 1'b0;
    end else if (flush) begin
      vld      <= 1'b0;
      q.rf_we  <= 1'b0;
      q.mem_we <= 1'b0;
      q.mem_re <= 1'b0;
    end else if (!stall) begin
      q   <= d;
      vld <= bus.in_valid;
    end
  end

  flag_reg u_flag (
    .clk      (clk),
    .rst_n    (rst_n),
    .c_ex_we  (exec & bus.alu_op[ALU_OP_CARRY_BIT]),
    .c_ex     (bus.alu_carry),
    .z_ex_we  (exec & bus.alu_op[ALU_OP_ZERO_BIT]),
    .z_ex     (bus.alu_zero),
    .z_mem_we (mem_zero_we & ~stall),
    .z_mem    (mem_zero),
    .carry    (bus.carry_flag),
    .zero     (bus.zero_flag)
  );

  assign bus.out_valid      = vld;
  assign bus.result         = q.result;
  assign bus.rd_out         = q.rd;
  assign bus.rf_we_out      = q.rf_we;
  assign bus.mem_we_out     = q.mem_we;
  assign bus.mem_re_out     = q.mem_re;
  assign bus.store_data_out = q.store_data;
  assign bus.pc_out         = q.pc;

endmodule

// File: tb/tb_ex_mem_latch.sv
// Scoreboard bench for ex_mem_latch.
// Directed test-plan cycles followed by random traffic.
module tb_ex_mem_latch;
  import iitb_pkg::*;

  typedef struct {
    logic        v;
    logic [15:0] res;
    logic [2:0]  rd;
    logic        rf;
    logic        mw;
    logic        mr;
    logic [15:0] sd;
    logic [15:0] pc;
    logic        c;
    logic        z;
    logic        known;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0;
  logic flush = 1'b0;
  logic mem_zero_we = 1'b0;
  logic mem_zero = 1'b0;

  ex_mem_latch_if bus();

  ex_mem_latch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .mem_zero_we (mem_zero_we),
    .mem_zero    (mem_zero),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  exp_t m;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // reference model: state after the coming edge
  task automatic model_push;
    if (!rst_n) begin
      m = '{default: '0};
      m.known = 1'b1;
    end else begin
      if (bus.in_valid && !stall && !flush && bus.alu_block_write_en) begin
        if (bus.alu_op[3]) m.c = bus.alu_carry;
        if (bus.alu_op[2]) m.z = bus.alu_zero;
        else if (mem_zero_we && !stall) m.z = mem_zero;
      end else if (mem_zero_we && !stall) begin
        m.z = mem_zero;
      end
      if (flush) begin
        m.v = 0; m.rf = 0; m.mw = 0; m.mr = 0;
        m.known = 0;
      end else if (!stall) begin
        m.v   = bus.in_valid;
        m.rf  = bus.in_valid && bus.alu_block_write_en && bus.rf_we_in;
        m.mw  = bus.in_valid && bus.alu_block_write_en && bus.mem_we_in;
        m.mr  = bus.in_valid && bus.alu_block_write_en && bus.mem_re_in;
        m.res = bus.alu_out;
        m.rd  = bus.rd_in;
        m.sd  = bus.store_data_in;
        m.pc  = bus.pc_in;
        m.known = 1;
      end
    end
    q.push_back(m);
  endtask

  task automatic drive(logic iv, logic [15:0] ao, logic ac, logic az,
                       logic bwe, logic [5:0] op, logic rfw);
    bus.in_valid = iv;
    bus.alu_out = ao;
    bus.alu_carry = ac;
    bus.alu_zero = az;
    bus.alu_block_write_en = bwe;
    bus.alu_op = op;
    bus.rd_in = 3'($urandom);
    bus.rf_we_in = rfw;
    bus.mem_we_in = 1'($urandom);
    bus.mem_re_in = 1'($urandom);
    bus.store_data_in = 16'($urandom);
    bus.pc_in = 16'($urandom);
  endtask

  task automatic step;
    model_push();
    @(negedge clk);
  endtask

  // monitor: compare DUT against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out_valid", 16'(bus.out_valid), 16'(e.v));
        chk("rf_we_out", 16'(bus.rf_we_out), 16'(e.rf));
        chk("mem_we_out", 16'(bus.mem_we_out), 16'(e.mw));
        chk("mem_re_out", 16'(bus.mem_re_out), 16'(e.mr));
        chk("carry_flag", 16'(bus.carry_flag), 16'(e.c));
        chk("zero_flag", 16'(bus.zero_flag), 16'(e.z));
        if (e.known) begin
          chk("result", bus.result, e.res);
          chk("rd_out", 16'(bus.rd_out), 16'(e.rd));
          chk("store_data_out", bus.store_data_out, e.sd);
          chk("pc_out", bus.pc_out, e.pc);
        end
      end
    end
  end

  initial begin
    m = '{default: '0};
    drive(1, 16'hFFFF, 1, 1, 1, 6'b001100, 1);
    @(negedge clk);
    rst_n = 0;
    step(); step();
    rst_n = 1;
    // ADD setting carry and zero
    drive(1, 16'h0000, 1, 1, 1, 6'b001100, 1);
    step();
    // skipped ADC
    drive(1, 16'h1234, 0, 0, 0, 6'b001110, 1);
    step();
    // NAND, no flag bits
    drive(1, 16'hBEEF, 0, 0, 1, 6'b010000, 1);
    step();
    // stall with changing inputs
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'($urandom), 1'($urandom), 1'($urandom), 1,
            6'b001100, 1);
      step();
    end
    flush = 1;
    step();
    stall = 0;
    flush = 0;
    // simultaneous zero writers, EX wins
    mem_zero_we = 1;
    mem_zero = 1;
    drive(1, 16'h0001, 0, 0, 1, 6'b000100, 1);
    step();
    drive(0, 16'h0002, 0, 0, 1, 6'b000000, 0);
    step();
    mem_zero_we = 0;
    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      mem_zero_we = 1'($urandom);
      mem_zero = 1'($urandom);
      drive(1'($urandom), 16'($urandom), 1'($urandom),
            1'($urandom), ($urandom_range(0, 3) != 0),
            6'($urandom), 1'($urandom));
      step();
    end
    rst_n = 1;
    stall = 0;
    flush = 0;
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 16'(q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
